// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready on both sides; one carry block per stage.
// Optional: define CSEL_ADDER_SAT_EN to saturate the sum on signed overflow.
module pipelined_csel_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NUM_BLOCKS = WIDTH / BLOCK;

  if (((WIDTH % BLOCK) != 0) || (NUM_BLOCKS < 1)) begin : g_bad_cfg
    $error("pipelined_csel_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  // Level k holds the conditioned operands, the carry into block k and the sum bits below block k.
  logic             v_q      [NUM_BLOCKS];
  logic             v_d      [NUM_BLOCKS];
  logic             c_q      [NUM_BLOCKS];
  logic             c_d      [NUM_BLOCKS];
  logic [WIDTH-1:0] a_q      [NUM_BLOCKS];
  logic [WIDTH-1:0] a_d      [NUM_BLOCKS];
  logic [WIDTH-1:0] b_q      [NUM_BLOCKS];
  logic [WIDTH-1:0] b_d      [NUM_BLOCKS];
  logic [WIDTH-1:0] s_q      [NUM_BLOCKS];
  logic [WIDTH-1:0] s_d      [NUM_BLOCKS];
  logic [BLOCK:0]   blk0_s   [NUM_BLOCKS];
  logic [BLOCK:0]   blk1_s   [NUM_BLOCKS];
  logic [WIDTH-1:0] merged_s [NUM_BLOCKS];
  logic             carry_s  [NUM_BLOCKS];

  logic             adv_s;
  logic [WIDTH-1:0] res_s;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  assign adv_s     = !out_valid_q || out_ready;
  assign in_ready  = adv_s;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // Both candidate block sums are formed in parallel; the registered carry only drives the select.
  always_comb begin
    for (int k = 0; k < NUM_BLOCKS; k++) begin
      blk0_s[k]   = {1'b0, a_q[k][k*BLOCK +: BLOCK]} + {1'b0, b_q[k][k*BLOCK +: BLOCK]};
      blk1_s[k]   = {1'b0, a_q[k][k*BLOCK +: BLOCK]} + {1'b0, b_q[k][k*BLOCK +: BLOCK]}
                    + {{BLOCK{1'b0}}, 1'b1};
      merged_s[k] = s_q[k];
      merged_s[k][k*BLOCK +: BLOCK] = c_q[k] ? blk1_s[k][BLOCK-1:0] : blk0_s[k][BLOCK-1:0];
      carry_s[k]  = c_q[k] ? blk1_s[k][BLOCK] : blk0_s[k][BLOCK];
    end
  end

  // Next-state of each level: level 0 captures conditioned operands, level k takes level k-1.
  always_comb begin
    v_d[0] = in_valid;
    a_d[0] = a;
    b_d[0] = sub ? ~b : b;
    c_d[0] = sub ? ~cin : cin;
    s_d[0] = {WIDTH{1'b0}};
    for (int k = 1; k < NUM_BLOCKS; k++) begin
      v_d[k] = v_q[k-1];
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      c_d[k] = carry_s[k-1];
      s_d[k] = merged_s[k-1];
    end
  end

  // Final result, overflow flag and (optionally) the saturation mux.
  always_comb begin
    res_s = merged_s[NUM_BLOCKS-1];
    ovf_d = (a_q[NUM_BLOCKS-1][WIDTH-1] == b_q[NUM_BLOCKS-1][WIDTH-1]) &&
            (res_s[WIDTH-1] != a_q[NUM_BLOCKS-1][WIDTH-1]);
    sum_d = res_s;
`ifdef CSEL_ADDER_SAT_EN
    if (ovf_d) begin
      sum_d = a_q[NUM_BLOCKS-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sum_d = res_s;
    end
`endif
  end

  // Stage registers: a rigid shift register gated by adv.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= {WIDTH{1'b0}};
        b_q[k] <= {WIDTH{1'b0}};
        s_q[k] <= {WIDTH{1'b0}};
      end
    end else if (adv_s) begin
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        v_q[k] <= v_d[k];
        c_q[k] <= c_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  // Output register; data only loads with a valid beat so the fields stay put between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= {WIDTH{1'b0}};
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (adv_s) begin
      out_valid_q <= v_q[NUM_BLOCKS-1];
      if (v_q[NUM_BLOCKS-1]) begin
        sum_q  <= sum_d;
        cout_q <= carry_s[NUM_BLOCKS-1];
        ovf_q  <= ovf_d;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Self-checking bench for pipelined_csel_adder (WIDTH=32, BLOCK=8): directed cases plus random traffic.
module tb_pipelined_csel_adder;
  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  res_t        exp_q[$];
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  int          n_sent = 0;
  int          n_rx = 0;
  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic        sc [8];
  logic        ss [8];

  pipelined_csel_adder #(.WIDTH(32), .BLOCK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: exact integer arithmetic on unsigned and signed interpretations.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic s);
    res_t        r;
    logic [32:0] u;
    longint      sx;
    longint      sy;
    longint      sr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      u      = {1'b0, x} - {1'b0, y} - {32'd0, ci};
      r.cout = ~u[32];
      sr     = sx - sy - longint'(ci);
    end else begin
      u      = {1'b0, x} + {1'b0, y} + {32'd0, ci};
      r.cout = u[32];
      sr     = sx + sy + longint'(ci);
    end
    r.sum = u[31:0];
    r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef CSEL_ADDER_SAT_EN
    if (r.ovf) r.sum = (sr > 64'sd0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
    return r;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin n_fail++; $error("FAIL %s: got %h, expected %h", tag, got, exp); end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin n_fail++; $error("FAIL %s: got %b, expected %b", tag, got, exp); end
  endtask

  // Offer one beat until accepted (bounded), queueing the given expected result.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ci,
                      input logic s, input res_t e);
    bit done;
    done = 1'b0;
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin exp_q.push_back(e); n_sent++; done = 1'b1; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk1("send_accepted", done, 1'b1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    chk32("drain_pending", exp_q.size(), 32'd0);
  endtask

  // Output scoreboard: every output transfer must match the oldest outstanding beat.
  always @(negedge clk) begin
    res_t e;
    if (!rst && out_valid && out_ready) begin
      n_total++;
      assert (exp_q.size() != 0) n_pass++;
      else begin n_fail++; $error("FAIL unexpected_out: got sum %h, expected no result", sum); end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_rx++;
        chk32("sum", sum, e.sum);
        chk1("cout", cout, e.cout);
        chk1("ovf", ovf, e.ovf);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk32("rst_sum", sum, 32'd0);
    chk1("rst_cout", cout, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk1("in_ready_after_reset", in_ready, 1'b1);
    @(posedge clk); #1;

    // 1+1 with a latency of exactly four edges
    send(32'h1, 32'h1, 1'b0, 1'b0, '{32'h2, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("latency_out_valid", out_valid, (i == 4) ? 1'b1 : 1'b0);
    end
    @(posedge clk); #1;
    drain();

    // carry ripple, overflow, subtract, sub by zero
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b0});
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, '{32'hFFFFFFFF, 1'b1, 1'b0});
`ifdef CSEL_ADDER_SAT_EN
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h7FFFFFFF, 1'b0, 1'b1});
    send(32'h80000000, 32'h00000001, 1'b0, 1'b1, '{32'h80000000, 1'b1, 1'b1});
`else
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1});
    send(32'h80000000, 32'h00000001, 1'b0, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1});
`endif
    send(32'h00000005, 32'h00000007, 1'b0, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0});
    send(32'hA5C3_0F96, 32'h0, 1'b0, 1'b1, '{32'hA5C3_0F96, 1'b1, 1'b0});
    drain();

    // back-to-back stream with out_ready low in cycles 5..9
    for (int i = 0; i < 8; i++) begin
      sa[i] = $urandom; sb[i] = $urandom; sc[i] = 1'($urandom_range(0, 1)); ss[i] = 1'($urandom_range(0, 1));
    end
    begin
      int beat;
      beat = 0;
      for (int c = 0; c < 30; c++) begin
        out_ready = !(c >= 5 && c <= 9);
        in_valid  = (beat < 8);
        a = sa[beat % 8]; b = sb[beat % 8]; cin = sc[beat % 8]; sub = ss[beat % 8];
        @(negedge clk);
        if (c >= 5 && c <= 9) begin
          chk1("stall_in_ready", in_ready, 1'b0);
          chk1("stall_out_valid", out_valid, 1'b1);
          chk32("stall_sum_held", sum, exp_q[0].sum);
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(sa[beat], sb[beat], sc[beat], ss[beat]));
          n_sent++;
          beat++;
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk32("stream_beats_sent", beat, 32'd8);
    end
    drain();
    chk32("stream_rx_count", n_rx, n_sent);

    // random traffic with random backpressure and corner operands
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = ($urandom_range(0, 3) != 0);
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = ~a;
        1: a = 32'h7FFFFFFF;
        2: a = 32'h80000000;
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      @(negedge clk);
      if (in_valid && in_ready) begin exp_q.push_back(model(a, b, cin, sub)); n_sent++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    chk32("random_rx_count", n_rx, n_sent);

    // reset with three beats in flight
    send(32'h11111111, 32'h22222222, 1'b0, 1'b0, '{32'h33333333, 1'b0, 1'b0});
    send(32'h01010101, 32'h02020202, 1'b0, 1'b0, '{32'h03030303, 1'b0, 1'b0});
    send(32'h0000000A, 32'h00000003, 1'b0, 1'b1, '{32'h00000007, 1'b1, 1'b0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk1("async_rst_out_valid", out_valid, 1'b0);
    chk32("async_rst_sum", sum, 32'd0);
    n_sent = n_sent - exp_q.size();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk1("in_ready_after_midrst", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("no_stale_out_valid", out_valid, 1'b0);
    end
    @(posedge clk); #1;
    send(32'h01BC0100, 32'h0F100A01, 1'b0, 1'b0, '{32'h10CC0B01, 1'b0, 1'b0});
    drain();
    chk32("final_rx_count", n_rx, n_sent);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipelined_csel_adder.md
Name: pipelined_csel_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor with a valid/ready handshake on both sides.
- Operand width and block width are generic; the carry chain is cut into NUM_BLOCKS blocks, one pipeline stage per block.
- Each stage precomputes both block sums (carry-in 0 and 1) and selects on the registered carry from the previous stage.
- Used as the datapath adder in multi-cycle arithmetic units where fmax matters more than latency.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of BLOCK.
- BLOCK, 8, bits per carry-select block; NUM_BLOCKS = WIDTH/BLOCK (localparam, >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand transfer request.
- in_ready  output  1  adder can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; borrow-in for subtract.
- sub  input  1  0 = a+b+cin; 1 = a-b-cin.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result (wraps modulo 2^WIDTH).
- cout  output  1  carry-out for add; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Operand conditioning at accept:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Pipeline advance: adv = !out_valid || out_ready.
  - in_ready = adv (combinational, no dependence on in_valid).
  - When adv = 0 every stage register holds, including valid bits and partially computed sums.
  - Bubbles are not collapsed: the pipeline is a rigid shift register gated by adv.
- Stage k (k = 0..NUM_BLOCKS-1):
  - Registers: valid, carry, remaining upper operand bits, accumulated lower sum bits, sign bits for overflow.
  - Computes bits [k*BLOCK +: BLOCK] twice, with carry-in 0 and carry-in 1, and selects by the incoming carry.
  - Stage 0 uses c0.
- Latency and throughput:
  - Latency is exactly NUM_BLOCKS cycles: an accept at edge n gives out_valid = 1 after edge n+NUM_BLOCKS, provided no stall.
  - Throughput is one result per cycle when out_ready is held high.
- Output fields:
  - cout = carry out of bit WIDTH-1.
  - ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- Output hold: sum, cout and ovf stay stable while out_valid && !out_ready.
- Reset:
  - All stage valid bits clear; out_valid = 0; sum = 0; cout = 0; ovf = 0.
  - in_ready = 1 immediately after reset deassertion.
  - Reset mid-operation discards all in-flight results; nothing is emitted after reset.
- Simultaneous events:
  - An output transfer and an input transfer in the same cycle are legal.
  - The pipeline shifts by one; no data is lost or duplicated.
- Boundary cases:
  - WIDTH == BLOCK gives a single stage: latency 1, degenerating to a registered ripple block.
  - sub with b = 0 and cin = 0 yields sum = a and cout = 1.
- Elaboration: a WIDTH not divisible by BLOCK is an error (generate-time $error).

Optional Feature:
- Macro: CSEL_ADDER_SAT_EN.
- Defined: on ovf = 1, sum saturates.
  - Positive overflow (a[MSB] = 0) gives {1'b0, {WIDTH-1{1'b1}}}.
  - Negative overflow gives {1'b1, {WIDTH-1{1'b0}}}.
  - ovf is still asserted; cout is unchanged (raw carry).
  - The saturation mux sits in the final stage; latency is unchanged.
- Undefined: sum wraps modulo 2^WIDTH; no saturation logic is present.

Test Plan:
All cases use WIDTH=32, BLOCK=8, latency 4.
1. Reset, then a=0x00000001, b=0x00000001, cin=0, sub=0, one beat → out_valid on 4th cycle after accept; sum=0x00000002, cout=0, ovf=0.
2. Carry ripple across all blocks: a=0xFFFFFFFF, b=0x00000001 → sum=0x00000000, cout=1, ovf=0. Then a=b=0xFFFFFFFF, cin=1 → sum=0xFFFFFFFF, cout=1.
3. Signed overflow: a=0x7FFFFFFF, b=0x00000001, add → ovf=1. Expected sum is 0x80000000 without the macro and 0x7FFFFFFF with CSEL_ADDER_SAT_EN.
4. Subtract: a=0x00000005, b=0x00000007, sub=1, cin=0 → sum=0xFFFFFFFE, cout=0. Then a=0x80000000, b=1, sub=1 → ovf=1.
5. Backpressure: stream 8 back-to-back beats with out_ready low for cycles 5-9 → in_ready low during the stall; outputs are held; all 8 results arrive in order with none dropped or duplicated.
6. Reset asserted with 3 beats in flight → out_valid = 0 immediately (asynchronously) and no stale result appears after release. Then a=0x01BC0100, b=0x0F100A01 → sum=0x10CC0B01.
